cordic_sine_arbiter: RTL and testbench

Shares one cordicsine instance among N_REQ requesters. Round-robin arbitration selects one pending request, holds its angle on the unit, pulses update and tracks the unit's ready drop/rise. It then returns the result with the requester's ID over a valid/ready response channel. Sits between the shared cordicsine and the waveform/phase clients.

---
 rtl/cordic_sine_arbiter_pkg.sv | 33 +++
 rtl/cordic_sine_arbiter_pick.sv | 62 ++++++
 rtl/cordic_sine_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_cordic_sine_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_sine_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_sine_arbiter_pkg
// Purpose  : Shared definitions for the cordic_sine_arbiter slice. It holds
//            the controller state encoding, the default widths and limits,
//            and a small state-classification helper.
// Ports    : none (package)
// Options  : CORDIC_TIMEOUT_EN (see cordic_sine_arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package cordic_sine_arbiter_pkg;

  // Default data width; matches the shared cordicsine unit
  localparam int DATA_W_DEF  = 16;
  // Default watchdog limit, in cycles per wait state
  localparam int TIMEOUT_DEF = 64;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // True in the two states that wait on the cordic ready handshake
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WAIT_BUSY) || (s == ST_WAIT_DONE);
  endfunction

endpackage : cordic_sine_arbiter_pkg
`default_nettype wire

// File: rtl/cordic_sine_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_pick
// Purpose  : Combinational round-robin picker. The search starts one position
//            after ptr_i, wraps around, and returns the first pending request.
// Ports    : req_i   [N]      pending request vector
//            ptr_i   [IDX_W]  index of the most recently served requester
//            grant_o [N]      one-hot grant (all zero when nothing pending)
//            idx_o   [IDX_W]  index of the granted requester
//            any_o            at least one request is pending
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // 6 bits hold ptr+1+offset for N up to 16 (at most 2N-1)
  localparam int SW = 6;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [SW-1:0]  w_start;
  logic [SW-1:0]  w_off;
  logic [SW-1:0]  w_sum;
  logic [SW-1:0]  w_idx;
  logic           w_found;

  // Doubling the vector turns the wrap-around search into a plain shift:
  // w_rot[k] is the request at position (ptr+1+k) mod N.
  assign w_dbl   = {req_i, req_i};
  assign w_start = SW'(ptr_i) + SW'(1);
  assign w_rot   = N'(w_dbl >> w_start);

  // Lowest set bit of the rotated vector is the next requester in turn
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = SW'(k);
      end
    end
  end

  // Map the offset back to an absolute index; one subtraction is enough
  assign w_sum = w_start + w_off;
  assign w_idx = (w_sum >= SW'(N)) ? (w_sum - SW'(N)) : w_sum;

  assign any_o   = w_found;
  assign idx_o   = IDX_W'(w_idx);
  assign grant_o = w_found ? (N'(1) << w_idx) : '0;

endmodule : rr_arbiter_pick
`default_nettype wire

// File: rtl/cordic_sine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_sine_arbiter
// Purpose  : Shares one cordicsine unit among N_REQ requesters. A round-robin
//            pick selects a pending request in IDLE, its angle is held on the
//            unit, update is pulsed, and the ready drop/rise of the unit is
//            tracked. The result goes back with the requester index over a
//            valid/ready response channel.
// Ports    : clk, reset           clock, synchronous active-high reset
//            req_valid_i/ready_o  per-requester handshake (ready one-hot)
//            req_angle_i          packed angles, requester i at [i*DATA_W+:DATA_W]
//            cs_update_o          update pulse to cordicsine
//            cs_angle_o           held in_angle to cordicsine
//            cs_ready_i           cordicsine ready
//            cs_result_i          cordicsine out_angle
//            rsp_valid_o/ready_i  response handshake
//            rsp_id_o             index of the served requester
//            rsp_data_o           sine result
//            rsp_err_o            watchdog timeout flag
//            busy_o               high in every state except IDLE
// Options  : CORDIC_TIMEOUT_EN - when defined, an 8-bit watchdog bounds each
//            wait state to TIMEOUT_CYCLES cycles and reports a timeout as a
//            response with rsp_err_o=1 and rsp_data_o=0. When undefined,
//            rsp_err_o is tied low and the wait states have no bound.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_sine_arbiter
  import cordic_sine_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_angle_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    cs_update_o,
  output logic [DATA_W-1:0]       cs_angle_o,
  input  logic                    cs_ready_i,
  input  logic [DATA_W-1:0]       cs_result_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    busy_o
);

  state_e              state_q,     state_d;
  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [DATA_W-1:0]   cs_angle_q,  cs_angle_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0]    w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_any;
  logic                w_accept;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_sel_angle;

  // --------------------------------------------------------------------------
  // Round-robin selection
  // --------------------------------------------------------------------------
  rr_arbiter_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  // Angle of the granted requester, selected by the one-hot grant
  always_comb begin
    w_sel_angle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_angle = req_angle_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_accept = (state_q == ST_IDLE) && w_any;

  // --------------------------------------------------------------------------
  // Controller: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      cs_angle_q  <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cs_angle_q  <= cs_angle_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Controller: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cs_angle_d  = cs_angle_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          cs_angle_d = w_sel_angle;
          rsp_id_d   = w_idx;
          rr_ptr_d   = w_idx;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end

      // The unit idles with ready high, so its drop must be seen before the
      // rise can be trusted as completion of this job.
      ST_WAIT_BUSY: begin
        if (!cs_ready_i) begin
          state_d = ST_WAIT_DONE;
        end else if (w_timeout) begin
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_WAIT_DONE: begin
        if (cs_ready_i) begin
          rsp_data_d  = cs_result_i;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (w_timeout) begin
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      // No new accept while leaving RESP; arbitration resumes in IDLE
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional watchdog
  // --------------------------------------------------------------------------
`ifdef CORDIC_TIMEOUT_EN
  // The counter starts at 0 on the first cycle of a wait state, so the value
  // TIMEOUT_CYCLES-1 marks the last of TIMEOUT_CYCLES waiting cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_q;
  logic       rsp_err_q;
  logic       w_in_wait;
  logic       w_wd_entry;

  assign w_in_wait  = is_wait_state(state_q);
  assign w_wd_entry = (state_d != state_q) && is_wait_state(state_d);
  assign w_timeout  = w_in_wait && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else if (w_wd_entry) begin
      wd_q <= '0;
    end else if (w_in_wait) begin
      wd_q <= wd_q + 8'd1;
    end
  end

  // Error flag stays with the response and is dropped by the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (w_accept) begin
      rsp_err_q <= 1'b0;
    end else if (w_timeout && (state_d == ST_RESP)) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  // Without the watchdog the limit has no role
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);

  assign w_timeout = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Grants are only offered in IDLE and never while reset is held
  assign req_ready_o = ((state_q == ST_IDLE) && !reset) ? w_grant : '0;
  assign cs_update_o = (state_q == ST_ISSUE);
  assign cs_angle_o  = cs_angle_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule : cordic_sine_arbiter
`default_nettype wire

// File: tb/tb_cordic_sine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_sine_arbiter
// Purpose  : Directed self-checking bench for cordic_sine_arbiter with a
//            behavioural stand-in for the shared cordicsine unit.
// Options  : CORDIC_TIMEOUT_EN selects the watchdog expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_sine_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_angle;
  logic [3:0]  req_ready;
  logic        cs_update;
  logic [15:0] cs_angle;
  logic        cs_ready  = 1'b1;
  logic [15:0] cs_result = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit stuck = 1'b0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  cordic_sine_arbiter #(
    .N_REQ          (4),
    .ID_W           (2),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_angle_i (req_angle),
    .req_ready_o (req_ready),
    .cs_update_o (cs_update),
    .cs_angle_o  (cs_angle),
    .cs_ready_i  (cs_ready),
    .cs_result_i (cs_result),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  // Reference result: sin(pi/4) in Q13 for 0x1922, a fixed scramble otherwise
  function automatic logic [15:0] golden(input logic [15:0] a);
    if (a == 16'h1922) return 16'h16A1;
    return {a[7:0], a[15:8]} ^ 16'h0F0F;
  endfunction

  // Cordic stand-in: ready drops after update, rises 5 cycles later with result
  always @(posedge clk) begin
    if (cs_ready) begin
      if (cs_update && !stuck) begin
        cs_ready <= 1'b0;
        m_cnt    <= 5;
      end
    end else begin
      if (m_cnt == 1) begin
        cs_ready  <= 1'b1;
        cs_result <= golden(cs_angle);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 4'b0; rsp_ready = 1'b0; req_angle = '0;
    tick(); tick();
    reset = 1'b0; #1;
    total++; if (req_ready !== 4'b0)  begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    total++; if (cs_update !== 1'b0)  begin bad++; $display("FAIL reset_cs_update: got %b want 0", cs_update); end
    total++; if (cs_angle !== 16'h0)  begin bad++; $display("FAIL reset_cs_angle: got %h want 0", cs_angle); end
    total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_id !== 2'd0)     begin bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    total++; if (rsp_data !== 16'h0)  begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    total++; if (rsp_err !== 1'b0)    begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    bit ok;
    bit held;
    int d;
    req_angle[15:0] = 16'h1922; req_valid = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick(); req_valid = 4'b0000;
    total++; if (cs_update !== 1'b1 || cs_angle !== 16'h1922 || busy !== 1'b1)
      begin bad++; $display("FAIL single_issue: got upd=%b ang=%h busy=%b want 1 1922 1", cs_update, cs_angle, busy); end
    tick();
    total++; if (cs_update !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", cs_update); end
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_rsp_wait: got no rsp_valid want 1"); end
    d = int'(rsp_data) - 5793;
    total++; if (rsp_id !== 2'd0 || d < -2 || d > 2)
      begin bad++; $display("FAIL single_rsp: got id=%0d data=%h want 0 16a1(+-2)", rsp_id, rsp_data); end
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h16A1) held = 1'b0;
    end
    total++; if (!held) begin bad++; $display("FAIL single_hold: got valid=%b data=%h want 1 16a1", rsp_valid, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL single_done: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    bit ok;
    bit rdy_bad;
    logic [3:0] want;
    for (int i = 0; i < 4; i++) req_angle[i*16 +: 16] = 16'h1000 + 16'(i * 16'h0111);
    reset = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0; #1;
    for (int g = 0; g < 5; g++) begin
      want = 4'b0001 << exp_id[g];
      total++; if (req_ready !== want || busy !== 1'b0)
        begin bad++; $display("FAIL rr_grant%0d: got %b busy=%b want %b 0", g, req_ready, busy, want); end
      tick();
      if (g == 4) req_valid = 4'h0;
      rdy_bad = 1'b0; ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
        if (req_ready !== 4'b0) rdy_bad = 1'b1;
        if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
        tick();
      end
      total++; if (!ok || rdy_bad || rsp_id !== 2'(exp_id[g]) || rsp_data !== golden(req_angle[exp_id[g]*16 +: 16]))
        begin bad++; $display("FAIL rr_rsp%0d: got ok=%b rdy_bad=%b id=%0d data=%h want 1 0 %0d %h",
                              g, ok, rdy_bad, rsp_id, rsp_data, exp_id[g], golden(req_angle[exp_id[g]*16 +: 16])); end
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_hold;
    bit ok;
    req_angle[31:16] = 16'h2345; req_angle[47:32] = 16'h0ABC;
    req_valid = 4'b0110; rsp_ready = 1'b0; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL hold_grant: got %b want 0010", req_ready); end
    tick(); req_valid = 4'b0100;
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL hold_rsp_wait: got no rsp_valid want 1"); end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== golden(16'h2345) ||
          cs_angle !== 16'h2345 || req_ready !== 4'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got v=%b id=%0d d=%h ang=%h rdy=%b want 1 1 %h 2345 0000",
                 i, rsp_valid, rsp_id, rsp_data, cs_angle, req_ready, golden(16'h2345));
      end
      tick();
    end
    rsp_ready = 1'b1; #1;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL hold_no_accept_in_resp: got %b want 0000", req_ready); end
    tick(); rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0100)
      begin bad++; $display("FAIL hold_next_grant: got v=%b rdy=%b want 0 0100", rsp_valid, req_ready); end
    tick(); req_valid = 4'b0;
    wait_rsp(ok);
    total++; if (!ok || rsp_id !== 2'd2 || rsp_data !== golden(16'h0ABC))
      begin bad++; $display("FAIL hold_second_rsp: got ok=%b id=%0d d=%h want 1 2 %h", ok, rsp_id, rsp_data, golden(16'h0ABC)); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit quiet;
    req_angle[63:48] = 16'h0777; req_valid = 4'b1000; #1;
    tick(); req_valid = 4'b0;
    tick(); tick();
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || cs_ready !== 1'b0)
      begin bad++; $display("FAIL rmid_pre: got busy=%b v=%b csr=%b want 1 0 0", busy, rsp_valid, cs_ready); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (req_ready !== 4'b0 || cs_update !== 1'b0 || cs_angle !== 16'h0 || rsp_valid !== 1'b0 ||
                 rsp_id !== 2'd0 || rsp_data !== 16'h0 || rsp_err !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL rmid_reset_vals: got rdy=%b upd=%b ang=%h v=%b id=%0d d=%h e=%b busy=%b want all 0",
                            req_ready, cs_update, cs_angle, rsp_valid, rsp_id, rsp_data, rsp_err, busy); end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet || cs_ready !== 1'b1)
      begin bad++; $display("FAIL rmid_stale_ready: got quiet=%b csr=%b want 1 1", quiet, cs_ready); end
  endtask

  task automatic test_skip;
    bit ok;
    reset = 1'b1; tick(); reset = 1'b0;
    req_angle[15:0] = 16'h0100; req_valid = 4'b0001;
    tick(); req_valid = 4'b0;
    wait_rsp(ok);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    req_angle[31:16] = 16'h1111; req_angle[47:32] = 16'h2222; req_angle[63:48] = 16'h3333;
    req_valid = 4'b1110; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL skip_grant1: got %b want 0010", req_ready); end
    tick(); req_valid = 4'b1000;
    wait_rsp(ok);
    total++; if (!ok || rsp_id !== 2'd1) begin bad++; $display("FAIL skip_rsp1: got ok=%b id=%0d want 1 1", ok, rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL skip_grant3: got %b want 1000", req_ready); end
    tick(); req_valid = 4'b0;
    wait_rsp(ok);
    total++; if (!ok || rsp_id !== 2'd3 || rsp_data !== golden(16'h3333))
      begin bad++; $display("FAIL skip_rsp3: got ok=%b id=%0d d=%h want 1 3 %h", ok, rsp_id, rsp_data, golden(16'h3333)); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    stuck = 1'b1;
    req_angle[15:0] = 16'h0500; req_valid = 4'b0001; #1;
    tick(); req_valid = 4'b0;
    total++; if (cs_update !== 1'b1) begin bad++; $display("FAIL to_issue: got %b want 1", cs_update); end
    n = 0;
    while (n < 100 && rsp_valid !== 1'b1) begin
      tick();
      n++;
    end
`ifdef CORDIC_TIMEOUT_EN
    total++; if (n !== 65) begin bad++; $display("FAIL to_latency: got %0d want 65", n); end
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || rsp_id !== 2'd0)
      begin bad++; $display("FAIL to_rsp: got v=%b e=%b d=%h id=%0d want 1 1 0 0", rsp_valid, rsp_err, rsp_data, rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    stuck = 1'b0;
    req_angle[31:16] = 16'h0600; req_valid = 4'b0010;
    tick(); req_valid = 4'b0;
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b want 0", rsp_err); end
    n = 0;
    while (n < 60 && rsp_valid !== 1'b1) begin
      tick();
      n++;
    end
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_id !== 2'd1 || rsp_data !== golden(16'h0600))
      begin bad++; $display("FAIL to_after: got v=%b e=%b id=%0d d=%h want 1 0 1 %h", rsp_valid, rsp_err, rsp_id, rsp_data, golden(16'h0600)); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`else
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || rsp_err !== 1'b0)
      begin bad++; $display("FAIL to_no_watchdog: got v=%b busy=%b e=%b want 0 1 0", rsp_valid, busy, rsp_err); end
    stuck = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_recover: got busy=%b want 0", busy); end
`endif
  endtask

  initial begin
    reset = 1'b1; req_valid = 4'b0; req_angle = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_skip();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish before 100000ns");
    $fatal(1, "bench time limit");
  end

endmodule : tb_cordic_sine_arbiter
`default_nettype wire
